// File: rtl/muldiv_sequencer_if.sv
// Pipeline-side bundle for the HI/LO multiply/divide sequencer.
// The master side is the EXE stage and hazard logic; the slave side is the sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             inStart;
  logic [1:0]       inOp;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             inRdHiLo;
  logic             inWrHi;
  logic             inWrLo;
  logic [WIDTH-1:0] inWrData;
  logic [WIDTH-1:0] outHI;
  logic [WIDTH-1:0] outLO;
  logic             outBusy;
  logic             outDone;
  logic             outStall;

  modport master (
    output inStart, inOp, inA, inB, inRdHiLo, inWrHi, inWrLo, inWrData,
    input  outHI, outLO, outBusy, outDone, outStall
  );

  modport slave (
    input  inStart, inOp, inA, inB, inRdHiLo, inWrHi, inWrLo, inWrData,
    output outHI, outLO, outBusy, outDone, outStall
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall request.
// Optional MULDIV_EARLY_TERM_EN: multiplies leave RUN once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | accepts start and MTHI/MTLO writes
// RUN   | one shift-add (mul) or restoring subtract (div) step per cycle
// FIX   | apply result signs; HI/LO load on the exit edge
// DONE  | result visible, outDone pulse
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic                inClk,
  input logic                inReset,
  muldiv_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state, stateNext;
  logic [1:0]         opReg;
  logic               negQ, negR;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   hiReg, loReg;

  logic               signedOp, signA, signB, divZero;
  logic [WIDTH-1:0]   absA, absB;
  logic [2*WIDTH-1:0] mulSum, divNext;
  logic [WIDTH:0]     remShift, trial;
  logic [WIDTH-1:0]   fixHi, fixLo;
  logic               earlyExit;

  always_comb begin
    signedOp = ~bus.inOp[0];
    signA    = signedOp & bus.inA[WIDTH-1];
    signB    = signedOp & bus.inB[WIDTH-1];
    absA     = signA ? -bus.inA : bus.inA;
    absB     = signB ? -bus.inB : bus.inB;
    divZero  = bus.inOp[1] && (bus.inB == '0);
  end

  // prod holds the accumulating product, or {remainder, dividend/quotient} for divides
  always_comb begin
    mulSum   = prod + (mplier[0] ? mcand : '0);
    remShift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    trial    = remShift - {1'b0, mcand[WIDTH-1:0]};
    divNext  = trial[WIDTH] ? {remShift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                            : {trial[WIDTH-1:0],    prod[WIDTH-2:0], 1'b1};
    fixHi    = prod[2*WIDTH-1:WIDTH];
    fixLo    = prod[WIDTH-1:0];
    if (!opReg[1]) begin
      if (negQ) {fixHi, fixLo} = -prod;
    end else begin
      if (negQ) fixLo = -prod[WIDTH-1:0];
      if (negR) fixHi = -prod[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
`ifdef MULDIV_EARLY_TERM_EN
    earlyExit = ~opReg[1] && (mplier[WIDTH-1:1] == '0);
`else
    earlyExit = 1'b0;
`endif
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (bus.inStart) stateNext = divZero ? FIX : RUN;
      RUN:  if (cnt == LAST_CNT || earlyExit) stateNext = FIX;
      FIX:  stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset) state <= IDLE;
    else         state <= stateNext;
  end

  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset) begin
      opReg  <= '0;
      negQ   <= 1'b0;
      negR   <= 1'b0;
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      hiReg  <= '0;
      loReg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.inWrHi) hiReg <= bus.inWrData;
          if (bus.inWrLo) loReg <= bus.inWrData;
          if (bus.inStart) begin
            opReg <= bus.inOp;
            cnt   <= '0;
            negQ  <= signA ^ signB;
            negR  <= signA;
            if (!bus.inOp[1]) begin
              prod   <= '0;
              mcand  <= {{WIDTH{1'b0}}, absA};
              mplier <= absB;
            end else if (divZero) begin
              // Divide by zero: raw dividend to HI, all ones to LO, no sign fix
              prod <= {bus.inA, {WIDTH{1'b1}}};
              negQ <= 1'b0;
              negR <= 1'b0;
            end else begin
              prod  <= {{WIDTH{1'b0}}, absA};
              mcand <= {{WIDTH{1'b0}}, absB};
            end
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (!opReg[1]) begin
            prod   <= mulSum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end else begin
            prod <= divNext;
          end
        end
        FIX: begin
          hiReg <= fixHi;
          loReg <= fixLo;
        end
        default: ;
      endcase
    end
  end

  assign bus.outHI    = hiReg;
  assign bus.outLO    = loReg;
  assign bus.outBusy  = (state != IDLE);
  assign bus.outDone  = (state == DONE);
  assign bus.outStall = bus.outBusy & (bus.inStart | bus.inRdHiLo | bus.inWrHi | bus.inWrLo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, hazard/reset sequences,
// and randomized operations against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  muldiv_sequencer_if #(.WIDTH(W)) bus();

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .inClk   (clk),
    .inReset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expHi;
    logic [W-1:0] expLo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic, returns {HI, LO}
  function automatic logic [63:0] refResult(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    p  = '0;
    case (op)
      2'd0: begin q = sa * sb; p = q; end
      2'd1: p = ua * ub;
      2'd2: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {(ua % ub) , 32'h0} | {32'h0, (ua / ub) & 64'hFFFF_FFFF};
      end
    endcase
    return p;
  endfunction

  // Edges from the start-sampling edge (counted as 1) to the edge that raises outDone
  function automatic int refCycles(input logic [1:0] op, input logic [W-1:0] b);
    int runs;
    logic [W-1:0] m;
    m = b;
    runs = W;
    if (op[1]) begin
      if (b == 0) runs = 0;
    end else begin
`ifdef MULDIV_EARLY_TERM_EN
      if (!op[0] && b[W-1]) m = -b;
      runs = 1;
      for (int i = 0; i < W; i++) if (m[i]) runs = i + 1;
`endif
    end
    return runs + 2;
  endfunction

  task automatic idleInputs();
    bus.inStart  = 1'b0;
    bus.inOp     = 2'd0;
    bus.inA      = '0;
    bus.inB      = '0;
    bus.inRdHiLo = 1'b0;
    bus.inWrHi   = 1'b0;
    bus.inWrLo   = 1'b0;
    bus.inWrData = '0;
  endtask

  task automatic startOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.inStart = 1'b1;
    bus.inOp    = op;
    bus.inA     = a;
    bus.inB     = b;
    tick();
    bus.inStart = 1'b0;
  endtask

  // Waits for outDone after a startOp; returns edges counted from the start edge
  task automatic waitDone(output int n);
    n = 1;
    while (!bus.outDone && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic runAndCheck(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [63:0] exp);
    int n;
    startOp(op, a, b);
    waitDone(n);
    check({tag, " done"}, 64'(bus.outDone), 64'd1);
    check({tag, " cycles"}, 64'(n), 64'(refCycles(op, b)));
    check({tag, " HI:LO"}, {bus.outHI, bus.outLO}, exp);
    tick();
    check({tag, " idle"}, 64'({bus.outBusy, bus.outDone}), 64'd0);
  endtask

  initial begin
    int n, badStall, doneSeen;
    logic [1:0] rop;
    logic [W-1:0] ra, rb;
    logic [63:0] r;

    idleInputs();
    vecs.push_back('{2'd0, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vecs.push_back('{2'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{2'd3, 32'd100,       32'd7,          32'd2,         32'd14});
    vecs.push_back('{2'd3, 32'h1234,      32'd0,          32'h1234,      32'hFFFF_FFFF});
    vecs.push_back('{2'd2, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF});
    vecs.push_back('{2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000});
    vecs.push_back('{2'd2, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD});
    vecs.push_back('{2'd1, 32'd5,         32'd3,          32'd0,         32'd15});
    vecs.push_back('{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'd1});
    vecs.push_back('{2'd0, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0});
    vecs.push_back('{2'd0, 32'd0,         32'd0,          32'd0,         32'd0});

    repeat (2) tick();
    check("reset HI:LO", {bus.outHI, bus.outLO}, 64'd0);
    check("reset busy/done", 64'({bus.outBusy, bus.outDone}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    foreach (vecs[i])
      runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  {vecs[i].expHi, vecs[i].expLo});

    // Async reset in the middle of RUN wipes HI/LO and suppresses the result
    @(negedge clk);
    bus.inWrHi = 1'b1; bus.inWrLo = 1'b1; bus.inWrData = 32'h5A5A_A5A5;
    tick();
    bus.inWrHi = 1'b0; bus.inWrLo = 1'b0;
    check("mt both", {bus.outHI, bus.outLO}, {32'h5A5A_A5A5, 32'h5A5A_A5A5});
    startOp(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) tick();
    check("pre-reset busy", 64'(bus.outBusy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid reset HI:LO", {bus.outHI, bus.outLO}, 64'd0);
    check("mid reset busy", 64'(bus.outBusy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.outDone || bus.outBusy) doneSeen++;
    end
    check("no done after reset", 64'(doneSeen), 64'd0);

    // MFHI in flight stalls through DONE and releases in IDLE with the new HI
    startOp(2'd0, 32'h0001_2345, 32'h8000_0001);
    repeat (4) tick();
    bus.inRdHiLo = 1'b1;
    #1;
    badStall = 0;
    n = 5;
    while (!bus.outDone && n < 200) begin
      if (!bus.outStall) badStall++;
      tick();
      n++;
    end
    check("mfhi cycles", 64'(n), 64'(refCycles(2'd0, 32'h8000_0001)));
    check("mfhi stall busy", 64'(badStall), 64'd0);
    check("mfhi stall done", 64'(bus.outStall), 64'd1);
    tick();
    check("mfhi stall idle", 64'(bus.outStall), 64'd0);
    r = refResult(2'd0, 32'h0001_2345, 32'h8000_0001);
    check("mfhi HI", 64'(bus.outHI), 64'(r[63:32]));
    bus.inRdHiLo = 1'b0;

    // MTLO while busy is held off; retried in IDLE it lands next edge
    startOp(2'd3, 32'd1000, 32'd3);
    tick();
    bus.inWrLo = 1'b1;
    bus.inWrData = 32'hCAFE_F00D;
    #1;
    check("mtlo busy stall", 64'(bus.outStall), 64'd1);
    repeat (3) tick();
    check("mtlo busy LO", 64'(bus.outLO), 64'(r[31:0]));
    bus.inWrLo = 1'b0;
    waitDone(n);
    check("mtlo div LO", 64'(bus.outLO), 64'd333);
    tick();
    bus.inWrLo = 1'b1;
    #1;
    check("mtlo idle stall", 64'(bus.outStall), 64'd0);
    tick();
    bus.inWrLo = 1'b0;
    check("mtlo idle LO", 64'(bus.outLO), 64'hCAFE_F00D);

    // Write coinciding with start: the result wins
    @(negedge clk);
    bus.inWrHi = 1'b1; bus.inWrData = 32'h1111_1111;
    bus.inStart = 1'b1; bus.inOp = 2'd1; bus.inA = 32'd6; bus.inB = 32'd7;
    tick();
    bus.inStart = 1'b0; bus.inWrHi = 1'b0;
    waitDone(n);
    check("wr+start result", {bus.outHI, bus.outLO}, 64'd42);
    tick();

    for (int k = 0; k < 40; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(0, 15));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      runAndCheck($sformatf("rnd%0d", k), rop, ra, rb, refResult(rop, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
